jtframe_sdram_arb: RTL

- Multi-requester scheduler in front of the single-port SDRAM controller. Shares one request/ack/data_rdy channel between N clients, e.g. several slot muxes or a mux plus a DMA/blitter.
- Fixed priority with an aging override so low-priority clients cannot starve.
- Inserts refresh permission when the bus is idle during vblank.

---
 rtl/jtframe_sdram_arb_pkg.sv | 14 +
 rtl/jtframe_sdram_arb_age.sv | 33 +++
 rtl/jtframe_sdram_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and constants for the SDRAM requester arbiter.
// Holds the FSM state encoding, the age counter width and the default address width.
package jtframe_sdram_arb_pkg;

   localparam int AGE_W      = 4;
   localparam int DEFAULT_AW = 22;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/jtframe_sdram_arb_age.sv
// Per-client saturating wait counter, updated only on the cycle a grant is issued (inc).
// clr marks the new owner; a client whose req is low at that moment also clears.
module jtframe_sdram_arb_age
   import jtframe_sdram_arb_pkg::*;
#(
   parameter int AGE_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             req,
   output logic [AGE_W-1:0] count,
   output logic             at_max
);

   localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         if (clr || !req) begin
            count <= '0;
         end else if (count != LIMIT) begin
            count <= count + 1'b1;
         end
      end
   end

   assign at_max = (count == LIMIT);

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Fixed-priority SDRAM arbiter (index 0 highest) with refresh permission during idle vblank.
// Define JTFRAME_ARB_AGING_EN to build the age counters that promote starved requesters.
module jtframe_sdram_arb
   import jtframe_sdram_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int AW      = DEFAULT_AW,
   parameter int AGE_MAX = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vblank,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    rnw,
   input  logic [N*AW-1:0] addr,
   input  logic [N*16-1:0] din,
   input  logic [N*2-1:0]  wrmask,
   output logic [N-1:0]    gnt,
   output logic [N-1:0]    dok,
   output logic [31:0]     dout,
   output logic            sdram_req,
   output logic            sdram_rnw,
   output logic [AW-1:0]   sdram_addr,
   output logic [15:0]     sdram_din,
   output logic [1:0]      sdram_wrmask,
   input  logic            sdram_ack,
   input  logic            data_rdy,
   input  logic [31:0]     data_read,
   output logic            refresh_en
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (N < 2 || N > 8 || AGE_MAX < 1 || AGE_MAX > (1 << AGE_W) - 1) begin : g_bad_param
      $error("jtframe_sdram_arb: N must be 2..8 and AGE_MAX must fit the age counter");
   end

   arb_state_t      state;
   logic [N-1:0]    age_at_max;
   logic [N-1:0]    win_oh;
   logic [IW-1:0]   win_idx;
   logic            any_req;
   logic            grant;
   logic            done;

   assign any_req = |req;
   assign grant   = (state == IDLE) && any_req;
   assign done    = data_rdy && (((state == REQ) && sdram_ack) || (state == WAIT));

   // An aged requester beats plain index priority; ties go to the lowest index.
   always_comb begin
      logic found;
      found   = 1'b0;
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && age_at_max[i]) begin
            found   = 1'b1;
            win_idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            win_idx = IW'(i);
         end
      end
      win_oh = {{(N-1){1'b0}}, 1'b1} << win_idx;
   end

`ifdef JTFRAME_ARB_AGING_EN
   for (genvar gi = 0; gi < N; gi++) begin : g_age
      jtframe_sdram_arb_age #(
         .AGE_MAX (AGE_MAX)
      ) u_age (
         .clk    (clk),
         .rst    (rst),
         .clr    (win_oh[gi]),
         .inc    (grant),
         .req    (req[gi]),
         .count  (),
         .at_max (age_at_max[gi])
      );
   end
`else
   assign age_at_max = '0;
`endif

   // Completion is handled after the case so a same-cycle ack+data_rdy in REQ lands in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         gnt          <= '0;
         dok          <= '0;
         dout         <= '0;
         sdram_req    <= 1'b0;
         sdram_rnw    <= 1'b1;
         sdram_addr   <= '0;
         sdram_din    <= '0;
         sdram_wrmask <= 2'b11;
         refresh_en   <= 1'b1;
      end else begin
         dok <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt          <= win_oh;
                  sdram_req    <= 1'b1;
                  sdram_rnw    <= rnw[win_idx];
                  sdram_addr   <= addr[win_idx*AW +: AW];
                  sdram_din    <= din[win_idx*16 +: 16];
                  sdram_wrmask <= rnw[win_idx] ? 2'b11 : wrmask[win_idx*2 +: 2];
                  refresh_en   <= 1'b0;
                  state        <= REQ;
               end else begin
                  refresh_en <= vblank;
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: ;
            default: state <= IDLE;
         endcase
         if (done) begin
            if (sdram_rnw) begin
               dout <= data_read;
            end
            dok   <= gnt;
            gnt   <= '0;
            state <= IDLE;
         end
      end
   end

endmodule
